booth_mul_arbiter: RTL and testbench

Shares one iterative radix-2 Booth multiplier among `NREQ` requesters.
- Arbitration is round-robin.
- The multiplier retires one Booth step per clock.
- Each response carries the requester index.
- The block sits between several arithmetic clients and a single shared multiply resource, replacing per-client combinational multipliers.

---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_iter_datapath.sv | 60 ++++++
 rtl/booth_mul_arbiter.sv | 117 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types, defaults and the round-robin pick used by the Booth multiplier arbiter.
package booth_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned MaxReq       = 32;
    localparam int unsigned MaxReqW      = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_e;

    // First asserted valid bit at or after (last+1) mod nreq; returns last if none is set.
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] valid,
                                            input int unsigned       last,
                                            input int unsigned       nreq = 4);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxReq; k++) begin
            idx = last + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && (k <= nreq) && valid[idx[MaxReqW-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/booth_iter_datapath.sv
// Iterative radix-2 Booth datapath: load latches A/S/P, each step does one add and one shift.
module booth_iter_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic [2*WIDTH+1:0]   p,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned AccW = WIDTH + 1;

    logic [AccW-1:0]    a_q, a_d;
    logic [AccW-1:0]    s_q, s_d;
    logic [2*WIDTH+1:0] p_q, p_d;
    logic [AccW-1:0]    m_ext;
    logic [AccW-1:0]    acc;

    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        a_d = a_q;
        s_d = s_q;
        p_d = p_q;
        acc = p_q[2*WIDTH+1:WIDTH+1];
        if (load) begin
            a_d = m_ext;
            // One extra accumulator bit keeps -(-2^(WIDTH-1)) representable.
            s_d = -m_ext;
            p_d = {{AccW{1'b0}}, q, 1'b0};
        end else if (step) begin
            case (p_q[1:0])
                2'b01:   acc = acc + a_q;
                2'b10:   acc = acc + s_q;
                default: acc = p_q[2*WIDTH+1:WIDTH+1];
            endcase
            p_d = {acc[AccW-1], acc, p_q[WIDTH:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            s_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            s_q <= s_d;
            p_q <= p_d;
        end
    end

    assign p       = p_q;
    assign product = p_q[2*WIDTH:1];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of one shared iterative Booth multiplier; responses carry the owner id.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter  int unsigned WIDTH = DefaultWidth,
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_multiplicand,
    input  logic [NREQ*WIDTH-1:0] req_multiplier,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    booth_state_e       state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic [MaxReq-1:0]  valid_ext;
    logic [IDW-1:0]     grant_idx;
    logic [WIDTH-1:0]   m_sel, q_sel;
    logic               load, step;
    logic [2*WIDTH+1:0] p_w;
    logic               unused_p;

    assign valid_ext = MaxReq'(req_valid);
    assign grant_idx = IDW'(rr_pick(valid_ext, 32'(last_q), NREQ));
    assign m_sel     = req_multiplicand[32'(grant_idx) * WIDTH +: WIDTH];
    assign q_sel     = req_multiplier[32'(grant_idx) * WIDTH +: WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        req_ready = '0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The grant is itself a valid requester, so any valid means acceptance.
                if (|req_valid) begin
                    req_ready[grant_idx] = 1'b1;
                    load    = 1'b1;
                    last_d  = grant_idx;
                    id_d    = grant_idx;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    booth_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .m       (m_sel),
        .q       (q_sel),
        .p       (p_w),
        .product (rsp_product)
    );

    assign unused_p  = ^p_w;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomized checks of booth_mul_arbiter against an arithmetic reference model.
module tb_booth_mul_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   mc;
    logic [N*W-1:0]   mp;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_product;
    logic [1:0]       rsp_id;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    booth_mul_arbiter #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (mc),
        .req_multiplier   (mp),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_product      (rsp_product),
        .rsp_id           (rsp_id),
        .busy             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mul_ref(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = $signed({{32{m[31]}}, m});
        b = $signed({{32{q[31]}}, q});
        return a * b;
    endfunction

    function automatic int rr_ref(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] m, input logic [31:0] q);
        req_valid[i]    = 1'b1;
        mc[i*W +: W]    = m;
        mp[i*W +: W]    = q;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < int'(W) + 8) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input int i, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input string tag);
        int n;
        set_req(i, m, q);
        #1;
        chk({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << i));
        tick();
        req_valid[i] = 1'b0;
        wait_rsp(n);
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_product"}, rsp_product, exp);
        chk({tag, "_id"}, 64'(rsp_id), 64'(i));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        handshake();
        chk({tag, "_idle_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] om [N];
        logic [31:0] oq [N];
        int          order [5];
        int          n, bad, g, model_last, last_acc, d;
        logic [63:0] exp;

        rst       = 1'b1;
        req_valid = '0;
        mc        = '0;
        mp        = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_product", rsp_product, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        txn(2, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "single");
        txn(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min");
        txn(1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_min");
        txn(3, 32'd0, 32'hFFFF_FFFF, 64'd0, "zero");

        // Response held in DONE while another requester waits.
        set_req(1, 32'd5, 32'd6);
        #1;
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(n);
        set_req(3, 32'd11, 32'hFFFF_FFFE);
        #1;
        bad = 0;
        repeat (10) begin
            if (rsp_valid !== 1'b1 || rsp_product !== 64'd30 || rsp_id !== 2'd1 ||
                req_ready !== 4'b0000) bad++;
            tick();
        end
        chk("done_hold_bad_cycles", 64'(bad), 64'd0);
        handshake();
        chk("done_exit_valid", 64'(rsp_valid), 64'd0);
        chk("done_exit_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(n);
        chk("pend_product", rsp_product, 64'hFFFF_FFFF_FFFF_FFEA);
        chk("pend_id", 64'(rsp_id), 64'd3);
        handshake();

        // All requesters valid out of reset; requester 0 re-requests right after its grant.
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            om[i] = 32'd100 + 32'(i);
            oq[i] = -(32'(i) + 32'd1) * 32'd3;
            set_req(i, om[i], oq[i]);
        end
        tick();
        rst = 1'b0;
        order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("all_grant", 64'(req_ready), 64'(4'b0001 << order[j]));
            exp = mul_ref(om[order[j]], oq[order[j]]);
            tick();
            req_valid[order[j]] = 1'b0;
            if (j == 0) begin
                om[0] = 32'd12345;
                oq[0] = 32'hFFFF_FD4A;
                set_req(0, om[0], oq[0]);
            end
            wait_rsp(n);
            chk("all_id", 64'(rsp_id), 64'(order[j]));
            chk("all_product", rsp_product, exp);
            handshake();
        end

        // Reset after ten steps discards the job; pointer restarts at requester 0.
        set_req(2, 32'd9, 32'd9);
        #1;
        tick();
        req_valid[2] = 1'b0;
        set_req(1, 32'hFFFF_FFF0, 32'd3);
        set_req(3, 32'd2, 32'd2);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_product", rsp_product, 64'd0);
        chk("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_regrant", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(n);
        chk("mid_rst_latency", 64'(n), 64'(W));
        chk("mid_rst_id", 64'(rsp_id), 64'd1);
        chk("mid_rst_product", rsp_product, 64'hFFFF_FFFF_FFFF_FFD0);
        handshake();
        #1;
        chk("mid_rst_next_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(n);
        chk("mid_rst_next_product", rsp_product, 64'd4);
        handshake();

        // Random back-to-back traffic against the reference model.
        model_last = 3;
        last_acc   = 0;
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) set_req(i, rnd_op(), rnd_op());
            end
            if (req_valid == '0) set_req(int'($urandom_range(0, N - 1)), rnd_op(), rnd_op());
            #1;
            g = rr_ref(req_valid, model_last);
            chk("rnd_grant", 64'(req_ready), 64'(4'b0001 << g));
            if (t > 0) begin
                d = cyc - last_acc;
                chk("rnd_interval", (d >= 34) ? 64'd34 : 64'(d), 64'd34);
            end
            last_acc = cyc;
            exp = mul_ref(mc[g*W +: W], mp[g*W +: W]);
            tick();
            req_valid[g] = 1'b0;
            model_last   = g;
            wait_rsp(n);
            chk("rnd_latency", 64'(n), 64'(W));
            chk("rnd_id", 64'(rsp_id), 64'(g));
            chk("rnd_product", rsp_product, exp);
            repeat ($urandom_range(0, 2)) tick();
            handshake();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
